usart_tx_fifo: RTL

Buffered USART transmitter: accepts parallel bytes over a valid/ready handshake into a small FIFO and serializes them as 8N1 frames (optionally 8E1/8O1) on `tx`. It is the transmit-side front end for host logic that produces bursts of bytes. It replaces direct toggle-driven transmission wherever back-pressure and queuing are needed. It sits between the byte producer and the pad, alongside the existing receiver in the USART controller.

---
 rtl/usart_tx_fifo.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/usart_tx_fifo.sv
// Buffered USART transmitter: byte FIFO feeding an 8N1 serializer.
// Optional parity bit compiled in with USART_TX_PARITY_EN.
module usart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BIT   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_BIT-1:0]              in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             tx,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int NW  = $clog2(FIFO_DEPTH + 1);
  localparam int BW  = $clog2(DATA_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef USART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [DATA_BIT-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_q, rd_q;
  logic [NW-1:0]       cnt_q;

  state_t              state_q, state_d;
  logic [CW-1:0]       baud_q, baud_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DATA_BIT-1:0] shift_q, shift_d;
  logic                tx_q, tx_d;
`ifdef USART_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  logic                push, pop, load, baud_end;
  logic [DATA_BIT-1:0] head;

  assign in_ready   = cnt_q != NW'(FIFO_DEPTH);
  assign fifo_count = cnt_q;
  assign busy       = state_q != IDLE;
  assign tx         = tx_q;
  assign push       = in_valid && in_ready;
  assign head       = mem_q[rd_q];
  assign baud_end   = baud_q == CW'(CPB - 1);

  // FIFO storage; only written on an accepted push
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + NW'(push) - NW'(pop);
    end
  end

  // Serializer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef USART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef USART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state: frame sequencing and FIFO pop
  always_comb begin
    state_d = state_q;
    baud_d  = baud_end ? '0 : baud_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    load    = 1'b0;
`ifdef USART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        load   = cnt_q != '0;
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_q == BW'(DATA_BIT - 1)) begin
`ifdef USART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef USART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          load    = cnt_q != '0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // pop the head straight into a start bit (from IDLE or end of STOP)
    if (load) begin
      state_d = START;
      baud_d  = '0;
      shift_d = head;
      tx_d    = 1'b0;
`ifdef USART_TX_PARITY_EN
      par_d   = ^head ^ 1'(PARITY_ODD);
`endif
    end
    pop = load;
  end

endmodule
